// File: rtl/regfile_pkg.sv
// Shared widths, frame layout and FSM encoding for the register-file dump transmitter.
package regfile_pkg;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 3;
  localparam int NUM_REGS   = 2 ** ADDR_W;
  localparam int FRAME_BITS = DATA_W + 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;
endpackage

// File: rtl/regfile_dump_tx_if.sv
// Request, register-file read port and serial link signals of the dump transmitter.
// Handshake: start is honoured only on an edge where busy = 0; busy stays high until the
// edge that raises the one-cycle done pulse, so start is never queued while busy.
interface regfile_dump_tx_if;
  import regfile_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] rf_read;
  logic [DATA_W-1:0] rf_dout;
  logic              txd;
  logic              busy;
  logic              done;

  modport master (
    output start, first_addr, last_addr, rf_dout,
    input  rf_read, txd, busy, done
  );

  modport slave (
    input  start, first_addr, last_addr, rf_dout,
    output rf_read, txd, busy, done
  );
endinterface

// File: rtl/regfile_tx_shifter.sv
// Serialises one byte as start bit, 8 data bits LSB first and stop bit, BIT_CYCLES clocks per bit.
module regfile_tx_shifter
  import regfile_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              txd,
  output logic              frame_done,
  output logic              bit_end,
  output logic [3:0]        bit_idx
);
  localparam int TICK_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  logic              active_q, active_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W:0]   shift_q, shift_d;
  logic              txd_q, txd_d;

  assign bit_end    = active_q && (tick_q == TICK_W'(BIT_CYCLES - 1));
  assign frame_done = bit_end && (idx_q == 4'(FRAME_BITS - 1));
  assign txd        = txd_q;
  assign bit_idx    = idx_q;

  always_comb begin
    active_d = active_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    txd_d    = txd_q;
    if (load) begin
      // The start bit goes out straight away; the stop bit rides in at the top of the shifter.
      active_d = 1'b1;
      tick_d   = '0;
      idx_d    = '0;
      shift_d  = {1'b1, data};
      txd_d    = 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        tick_d = '0;
        if (frame_done) begin
          active_d = 1'b0;
          txd_d    = 1'b1;
        end else begin
          idx_d   = idx_q + 4'd1;
          txd_d   = shift_q[0];
          shift_d = {1'b1, shift_q[DATA_W:1]};
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      tick_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      active_q <= active_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end
endmodule

// File: rtl/regfile_dump_tx.sv
// Walks a (possibly wrapping) register range, reads each register and sends it on the serial line.
module regfile_dump_tx
  import regfile_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int RD_LAT     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_dump_tx_if.slave       bus,
  output state_t                 state_o
);
  localparam int WAIT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rf_read_q, rf_read_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load;
  logic              txd;
  logic              frame_done;
  logic              bit_end;
  logic [3:0]        bit_idx;

  regfile_tx_shifter #(.BIT_CYCLES(BIT_CYCLES)) u_shifter (
    .clk        (clk),
    .rst_n      (reset),
    .load       (load),
    .data       (bus.rf_dout),
    .txd        (txd),
    .frame_done (frame_done),
    .bit_end    (bit_end),
    .bit_idx    (bit_idx)
  );

  assign bus.rf_read = rf_read_q;
  assign bus.txd     = txd;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign state_o     = state_q;

  always_comb begin
    state_d   = state_q;
    rf_read_d = rf_read_q;
    remain_d  = remain_q;
    wait_d    = wait_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // Bytes left after the first; modular subtraction handles the 7 -> 0 wrap.
          rf_read_d = bus.first_addr;
          remain_d  = bus.last_addr - bus.first_addr;
          wait_d    = '0;
          busy_d    = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (wait_q == WAIT_W'(RD_LAT)) begin
          load    = 1'b1;
          state_d = START;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA:  if (bit_end && (bit_idx == 4'(DATA_W))) state_d = STOP;
      STOP: begin
        if (frame_done) begin
          if (remain_q != '0) begin
            remain_d  = remain_q - 1'b1;
            rf_read_d = rf_read_q + 1'b1;
            wait_d    = '0;
            state_d   = FETCH;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rf_read_q <= '0;
      remain_q  <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rf_read_q <= rf_read_d;
      remain_q  <= remain_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_regfile_dump_tx.sv
// Self-checking bench for regfile_dump_tx: table of dump requests plus a mid-frame reset sequence.
module tb_regfile_dump_tx;
  import regfile_pkg::*;

  localparam int BIT_CYCLES = 4;
  localparam int RD_LAT     = 1;
  localparam int FETCH_CYC  = RD_LAT + 1;
  localparam int PER        = FETCH_CYC + 10 * BIT_CYCLES;

  typedef struct {
    logic [2:0] first;
    logic [2:0] last;
    int         n;
    int         exp_busy;
    int         poke_c;
    bit         chain;
  } vec_t;

  logic       clk;
  logic       reset;
  state_t     state_o;
  logic [7:0] regs [8];
  vec_t       vecs [5];
  vec_t       vec_r;
  int         n_checks;
  int         n_errors;

  regfile_dump_tx_if bus ();

  regfile_dump_tx #(.BIT_CYCLES(BIT_CYCLES), .RD_LAT(RD_LAT)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file read port with one cycle of latency
  always @(posedge clk) bus.rf_dout <= regs[bus.rf_read];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called one half-cycle after the edge that accepts the start request.
  task automatic run_dump(input vec_t v, input vec_t nx);
    int         total;
    int         last_c;
    int         b;
    int         p;
    int         k;
    int         errs;
    int         busy_cnt;
    logic [2:0] exp_rd;
    logic       exp_txd;
    logic [7:0] dec;
    total    = v.n * PER;
    last_c   = v.chain ? total : total + 1;
    errs     = 0;
    busy_cnt = 0;
    dec      = '0;
    for (int c = 0; c <= last_c; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cnt++;
      if (c < total) begin
        b      = c / PER;
        p      = c % PER;
        exp_rd = 3'(v.first + b);
        if (p < FETCH_CYC) exp_txd = 1'b1;
        else begin
          k = (p - FETCH_CYC) / BIT_CYCLES;
          if (k == 0)      exp_txd = 1'b0;
          else if (k == 9) exp_txd = 1'b1;
          else             exp_txd = regs[exp_rd][k-1];
          if (((p - FETCH_CYC) % BIT_CYCLES) == BIT_CYCLES / 2 && k >= 1 && k <= 8)
            dec[k-1] = bus.txd;
        end
        if (p == 0) chk("rf_read", bus.rf_read, exp_rd);
        if (bus.txd !== exp_txd || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.rf_read !== exp_rd)
          errs++;
        if (p == PER - 1) begin
          chk("byte", dec, regs[exp_rd]);
          chk("wave_errs", errs, 0);
          errs = 0;
        end
      end else if (c == total) begin
        chk("busy_end", bus.busy, 1'b0);
        chk("done", bus.done, 1'b1);
        chk("txd_idle", bus.txd, 1'b1);
        chk("rf_hold", bus.rf_read, 3'(v.first + v.n - 1));
        chk("busy_cycles", busy_cnt, v.exp_busy);
      end else begin
        chk("done_clear", bus.done, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
      end
      // driver
      bus.start = 1'b0;
      if (c == 0) begin
        bus.first_addr = 3'($urandom_range(0, 7));
        bus.last_addr  = 3'($urandom_range(0, 7));
      end
      if (c == v.poke_c) begin
        bus.start      = 1'b1;
        bus.first_addr = 3'd3;
        bus.last_addr  = 3'd3;
      end
      if (v.chain && c == total) begin
        bus.start      = 1'b1;
        bus.first_addr = nx.first;
        bus.last_addr  = nx.last;
      end
    end
  endtask

  task automatic drive_start(input logic [2:0] f, input logic [2:0] l);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.first_addr = f;
    bus.last_addr  = l;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.first_addr = '0;
    bus.last_addr  = '0;
    for (int i = 0; i < 8; i++) regs[i] = 8'(10 + i);

    //          first last  n  busy poke chain
    vecs[0] = '{3'd2, 3'd2, 1,  42,  -1, 1'b0};
    vecs[1] = '{3'd0, 3'd7, 8, 336,  -1, 1'b0};
    vecs[2] = '{3'd6, 3'd1, 4, 168,  50, 1'b0};
    vecs[3] = '{3'd4, 3'd3, 8, 336,  -1, 1'b1};
    vecs[4] = '{3'd7, 3'd0, 2,  84,  -1, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_txd", bus.txd, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_rf_read", bus.rf_read, 3'd0);
    chk("rst_state", 32'(state_o), 32'(IDLE));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_txd", bus.txd, 1'b1);

    for (int i = 0; i < 5; i++) begin
      if (i == 0 || !vecs[i-1].chain) begin
        repeat (2) @(negedge clk);
        drive_start(vecs[i].first, vecs[i].last);
      end
      run_dump(vecs[i], vecs[(i + 1) % 5]);
    end

    // Reset during DATA bit 3 of the second byte of a 0..3 dump.
    drive_start(3'd0, 3'd3);
    for (int c = 0; c <= PER + FETCH_CYC + 4 * BIT_CYCLES + 1; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("pre_rst_rf_read", bus.rf_read, 3'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_txd", bus.txd, 1'b1);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_rf_read", bus.rf_read, 3'd0);
    chk("arst_done", bus.done, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_hold_done", bus.done, 1'b0);
    chk("rst_hold_state", 32'(state_o), 32'(IDLE));
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_done", bus.done, 1'b0);
    vec_r = '{3'd5, 3'd5, 1, 42, -1, 1'b0};
    drive_start(vec_r.first, vec_r.last);
    run_dump(vec_r, vec_r);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
